term_inject_arb: RTL and testbench

- Injection scheduler for one terminal port of the mesh (`mesh_gnrtr`).
- Shares that terminal's input (`data_out_i_in` / `pndng_i_in` / `popin`) among NUM_REQ local packet sources, using round-robin arbitration.
- Holds each granted packet stable until the router pops it.
- Drops self-addressed packets, flags stuck transfers with a watchdog, and counts traffic.
- Sits between the local agents/traffic generators and one mesh terminal; one instance per terminal.

---
 rtl/router_arb_pkg.sv | 38 +++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/term_inject_arb.sv | 149 ++++++++++++++
 tb/tb_term_inject_arb.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_arb_pkg.sv
// ----------------------------------------------------------------------------
// router_arb_pkg
//   Packet header field layout, injection FSM state type and the
//   self-address test used by term_inject_arb.
//   Field offsets count down from the packet MSB, so the header decode does
//   not depend on the packet width.
// ----------------------------------------------------------------------------
package router_arb_pkg;

   // Header field widths
   localparam int NXT_JMP_W = 8;
   localparam int ROW_W     = 4;
   localparam int COL_W     = 4;
   localparam int MODE_W    = 1;

   // Header field offsets, measured down from the packet MSB
   localparam int NXT_JMP_OFS = 0;
   localparam int ROW_OFS     = NXT_JMP_OFS + NXT_JMP_W;
   localparam int COL_OFS     = ROW_OFS + ROW_W;
   localparam int MODE_OFS    = COL_OFS + COL_W;

   // Header span: the top HDR_W bits of any packet
   localparam int HDR_W = MODE_OFS + MODE_W;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } arb_state_t;

   // pkt is the packet header (its top HDR_W bits).
   function automatic logic is_self(input logic [HDR_W-1:0] pkt,
                                    input logic [ROW_W-1:0] row,
                                    input logic [COL_W-1:0] col);
      return (pkt[HDR_W-1-ROW_OFS -: ROW_W] == row) &&
             (pkt[HDR_W-1-COL_OFS -: COL_W] == col);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin priority rotator. The search starts at the
//   requester just above ptr and wraps, so ptr is the most recent winner.
// Ports:
//   req     in  N   request vector
//   ptr     in  IW  last granted index
//   en      in  1   grant enable; when low no grant is issued
//   gnt     out N   one-hot grant
//   gnt_idx out IW  index of the winner (0 when no request)
//   any     out 1   a grant is issued this cycle
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          any
);

   logic          found;
   logic [IW-1:0] idx;

   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      idx     = '0;
      for (int i = 1; i <= N; i++) begin
         idx = IW'((int'(ptr) + i) % N);
         if (!found && req[idx]) begin
            found   = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   assign any = en & found;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_gnt
         assign gnt[gi] = any && (gnt_idx == IW'(gi));
      end
   endgenerate

endmodule

// File: rtl/term_inject_arb.sv
// ----------------------------------------------------------------------------
// term_inject_arb
//   Shares one mesh terminal input among NUM_REQ local packet sources with
//   round-robin arbitration. A granted packet is held on the router port
//   until popin. Self-addressed packets are accepted and discarded. A
//   watchdog flags packets stuck in SEND, and sent/dropped packets are
//   counted with saturating counters.
// Ports:
//   clk            in   clock
//   reset          in   asynchronous active-low reset
//   req_vld        in   per-requester packet valid
//   req_data       in   per-requester packet
//   req_rdy        out  per-requester accept (combinational, one-hot, IDLE only)
//   data_out_i_in  out  packet to router terminal
//   pndng_i_in     out  packet pending to router
//   popin          in   router consumed the packet
//   grant_id       out  source of the packet currently held
//   busy           out  high while in SEND
//   timeout_err    out  sticky watchdog flag
//   clear_err      in   synchronous clear of timeout_err
//   sent_cnt       out  packets popped by router (saturating)
//   drop_cnt       out  self-addressed packets dropped (saturating)
// ----------------------------------------------------------------------------
module term_inject_arb
   import router_arb_pkg::*;
#(
   parameter int pckg_sz     = 32,
   parameter int NUM_REQ     = 4,
   parameter int ROW_ID      = 0,
   parameter int COL_ID      = 1,
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_W       = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req_vld,
   input  logic [NUM_REQ-1:0][pckg_sz-1:0]  req_data,
   output logic [NUM_REQ-1:0]               req_rdy,
   output logic [pckg_sz-1:0]               data_out_i_in,
   output logic                             pndng_i_in,
   input  logic                             popin,
   output logic [$clog2(NUM_REQ)-1:0]       grant_id,
   output logic                             busy,
   output logic                             timeout_err,
   input  logic                             clear_err,
   output logic [CNT_W-1:0]                 sent_cnt,
   output logic [CNT_W-1:0]                 drop_cnt
);

   localparam int GW   = $clog2(NUM_REQ);
   localparam int WD_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   // Watchdog value on the cycle before it reaches the timeout
   localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYC > 0) ? WD_W'(TIMEOUT_CYC - 1) : '0;
   localparam logic [ROW_W-1:0] MY_ROW = ROW_W'(ROW_ID);
   localparam logic [COL_W-1:0] MY_COL = COL_W'(COL_ID);

   arb_state_t          state_reg, state_next;
   logic [GW-1:0]       rr_ptr_reg;
   logic [GW-1:0]       grant_id_reg;
   logic [pckg_sz-1:0]  data_reg;
   logic                pndng_reg;
   logic [WD_W-1:0]     wd_reg;
   logic                err_reg;
   logic [CNT_W-1:0]    sent_reg;
   logic [CNT_W-1:0]    drop_reg;

   logic [NUM_REQ-1:0]  arb_gnt;
   logic [GW-1:0]       win_idx;
   logic                win_any;
   logic [pckg_sz-1:0]  win_data;
   logic                win_self;
   logic                pop_evt;
   logic                wd_hit;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req     (req_vld),
      .ptr     (rr_ptr_reg),
      .en      (state_reg == IDLE),
      .gnt     (arb_gnt),
      .gnt_idx (win_idx),
      .any     (win_any)
   );

   assign win_data = req_data[win_idx];
   assign win_self = is_self(win_data[pckg_sz-1 -: HDR_W], MY_ROW, MY_COL);
   assign pop_evt  = (state_reg == SEND) && popin;
   // Fires only on the edge the watchdog reaches the limit; once saturated
   // it stays quiet, so a later clear_err is honoured.
   assign wd_hit   = (TIMEOUT_CYC != 0) && (state_reg == SEND) && !popin &&
                     (wd_reg == WD_LAST);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (win_any && !win_self) state_next = SEND;
         SEND: if (popin)                state_next = IDLE;
         default:                        state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         rr_ptr_reg   <= GW'(NUM_REQ - 1);
         grant_id_reg <= '0;
         data_reg     <= '0;
         pndng_reg    <= 1'b0;
         wd_reg       <= '0;
         err_reg      <= 1'b0;
         sent_reg     <= '0;
         drop_reg     <= '0;
      end else begin
         state_reg <= state_next;

         if (win_any) begin
            rr_ptr_reg   <= win_idx;
            grant_id_reg <= win_idx;
            if (win_self) begin
               if (drop_reg != '1) drop_reg <= drop_reg + CNT_W'(1);
            end else begin
               data_reg  <= win_data;
               pndng_reg <= 1'b1;
            end
         end

         if (pop_evt) begin
            pndng_reg <= 1'b0;
            wd_reg    <= '0;
            if (sent_reg != '1) sent_reg <= sent_reg + CNT_W'(1);
         end else if ((TIMEOUT_CYC != 0) && (state_reg == SEND) &&
                      (wd_reg != WD_LAST + WD_W'(1))) begin
            wd_reg <= wd_reg + WD_W'(1);
         end

         if (wd_hit)         err_reg <= 1'b1;
         else if (clear_err) err_reg <= 1'b0;
      end
   end

   assign req_rdy       = arb_gnt;
   assign data_out_i_in = data_reg;
   assign pndng_i_in    = pndng_reg;
   assign grant_id      = grant_id_reg;
   assign busy          = (state_reg == SEND);
   assign timeout_err   = err_reg;
   assign sent_cnt      = sent_reg;
   assign drop_cnt      = drop_reg;

endmodule

// File: tb/tb_term_inject_arb.sv
module tb_term_inject_arb;

   localparam int NR = 4;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic [NR-1:0]        req_vld = '0;
   logic [NR-1:0][31:0]  req_data = '0;
   logic [NR-1:0]        req_rdy;
   logic [31:0]          data_out_i_in;
   logic                 pndng_i_in;
   logic                 popin = 1'b0;
   logic [1:0]           grant_id;
   logic                 busy;
   logic                 timeout_err;
   logic                 clear_err = 1'b0;
   logic [15:0]          sent_cnt;
   logic [15:0]          drop_cnt;

   // Second instance with narrow counters, driven by the same stimulus
   logic [NR-1:0]        s_req_rdy;
   logic [31:0]          s_data;
   logic                 s_pndng;
   logic [1:0]           s_grant_id;
   logic                 s_busy;
   logic                 s_timeout_err;
   logic [3:0]           s_sent_cnt;
   logic [3:0]           s_drop_cnt;

   always #5 clk = ~clk;

   term_inject_arb #(.pckg_sz(32), .NUM_REQ(NR), .ROW_ID(0), .COL_ID(1),
                     .TIMEOUT_CYC(64), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .req_vld(req_vld), .req_data(req_data),
      .req_rdy(req_rdy), .data_out_i_in(data_out_i_in), .pndng_i_in(pndng_i_in),
      .popin(popin), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err),
      .clear_err(clear_err), .sent_cnt(sent_cnt), .drop_cnt(drop_cnt)
   );

   term_inject_arb #(.pckg_sz(32), .NUM_REQ(NR), .ROW_ID(0), .COL_ID(1),
                     .TIMEOUT_CYC(64), .CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset), .req_vld(req_vld), .req_data(req_data),
      .req_rdy(s_req_rdy), .data_out_i_in(s_data), .pndng_i_in(s_pndng),
      .popin(popin), .grant_id(s_grant_id), .busy(s_busy), .timeout_err(s_timeout_err),
      .clear_err(clear_err), .sent_cnt(s_sent_cnt), .drop_cnt(s_drop_cnt)
   );

   typedef struct {
      int          src;
      logic [31:0] data;
   } pop_t;

   int   acc_q[$];
   pop_t pop_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_sent = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Scoreboard monitor: accepts and router pops are checked against queues
   always @(negedge clk) begin
      int   idx;
      int   e;
      pop_t p;
      if (reset) begin
         if (req_rdy != '0) begin
            idx = -1;
            for (int i = 0; i < NR; i++) if (req_rdy[i]) idx = i;
            chk("rdy_onehot", 64'($onehot(req_rdy)), 64'd1);
            if (acc_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_accept: req_rdy=%b, expected none", req_rdy);
            end else begin
               e = acc_q.pop_front();
               $display("accept src=%0d (expected %0d)", idx, e);
               chk("accept_src", 64'(idx), 64'(e));
            end
         end
         if (pndng_i_in && popin) begin
            if (pop_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_pop: data=%h, expected no packet", data_out_i_in);
            end else begin
               p = pop_q.pop_front();
               $display("pop src=%0d data=%h (expected src=%0d data=%h)",
                        grant_id, data_out_i_in, p.src, p.data);
               chk("pop_data", 64'(data_out_i_in), 64'(p.data));
               chk("pop_grant_id", 64'(grant_id), 64'(p.src));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_pkt(input int s, input logic [31:0] d);
      pop_t p;
      p.src  = s;
      p.data = d;
      acc_q.push_back(s);
      pop_q.push_back(p);
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      req_vld   = '0;
      popin     = 1'b0;
      clear_err = 1'b0;
      exp_sent  = 0;
      @(negedge clk);
      chk("rst_pndng", 64'(pndng_i_in), 64'd0);
      chk("rst_data", 64'(data_out_i_in), 64'd0);
      chk("rst_grant", 64'(grant_id), 64'd0);
      chk("rst_err", 64'(timeout_err), 64'd0);
      chk("rst_sent", 64'(sent_cnt), 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   // Single packet from one source, popped the cycle after it appears
   task automatic send_pkt(input int s, input logic [31:0] d);
      req_vld     = NR'(1 << s);
      req_data[s] = d;
      expect_pkt(s, d);
      tick();
      req_vld = '0;
      popin   = 1'b1;
      tick();
      popin   = 1'b0;
      exp_sent++;
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation still running, expected completion");
      $fatal(1, "global timeout");
   end

   initial begin
      // ---------------- basic send ----------------
      do_reset();
      req_data[0] = 32'h00FF_AAAA;
      req_vld     = 4'b0001;
      expect_pkt(0, 32'h00FF_AAAA);
      @(negedge clk);
      chk("t1_rdy", 64'(req_rdy), 64'h1);
      tick();
      req_vld     = '0;
      req_data[0] = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("t1_pndng", 64'(pndng_i_in), 64'd1);
      chk("t1_data", 64'(data_out_i_in), 64'h00FF_AAAA);
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_rdy_send", 64'(req_rdy), 64'd0);
      repeat (5) tick();
      @(negedge clk);
      chk("t1_data_held", 64'(data_out_i_in), 64'h00FF_AAAA);
      tick();
      popin = 1'b1;
      tick();
      popin = 1'b0;
      @(negedge clk);
      chk("t1_pndng_clr", 64'(pndng_i_in), 64'd0);
      chk("t1_sent", 64'(sent_cnt), 64'd1);
      chk("t1_busy_clr", 64'(busy), 64'd0);

      // ---------------- round robin ----------------
      do_reset();
      for (int i = 0; i < NR; i++) req_data[i] = 32'h00F0_0000 | (32'(i + 1) * 32'h1111);
      req_vld = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         expect_pkt(k % NR, req_data[k % NR]);
         tick();
         if (k == 4) req_vld = '0;
         popin = 1'b1;
         tick();
         popin = 1'b0;
      end
      exp_sent += 5;
      @(negedge clk);
      chk("rr_sent", 64'(sent_cnt), 64'(exp_sent));
      chk("rr_last_grant", 64'(grant_id), 64'd0);

      // ---------------- self-address drop ----------------
      do_reset();
      send_pkt(1, 32'h00F2_0001);
      req_data[0] = 32'h00F3_0000;
      req_data[2] = 32'h0001_2222;
      req_data[3] = 32'h00F3_3333;
      req_vld     = 4'b1101;
      acc_q.push_back(2);
      @(negedge clk);
      chk("drop_rdy", 64'(req_rdy), 64'h4);
      tick();
      expect_pkt(3, 32'h00F3_3333);
      @(negedge clk);
      chk("drop_pndng", 64'(pndng_i_in), 64'd0);
      chk("drop_cnt", 64'(drop_cnt), 64'd1);
      chk("drop_grant", 64'(grant_id), 64'd2);
      chk("drop_next_rdy", 64'(req_rdy), 64'h8);
      tick();
      req_vld = '0;
      popin   = 1'b1;
      tick();
      popin   = 1'b0;
      exp_sent++;
      @(negedge clk);
      chk("drop_sent", 64'(sent_cnt), 64'(exp_sent));

      // ---------------- watchdog ----------------
      do_reset();
      req_data[0] = 32'h00A5_0404;
      req_vld     = 4'b0001;
      expect_pkt(0, 32'h00A5_0404);
      tick();
      req_vld = '0;
      repeat (63) tick();
      @(negedge clk);
      chk("wd_before", 64'(timeout_err), 64'd0);
      tick();
      @(negedge clk);
      chk("wd_set", 64'(timeout_err), 64'd1);
      repeat (36) tick();
      @(negedge clk);
      chk("wd_sticky", 64'(timeout_err), 64'd1);
      chk("wd_data_held", 64'(data_out_i_in), 64'h00A5_0404);
      chk("wd_pndng_held", 64'(pndng_i_in), 64'd1);
      tick();
      popin = 1'b1;
      tick();
      popin = 1'b0;
      exp_sent++;
      @(negedge clk);
      chk("wd_sent", 64'(sent_cnt), 64'(exp_sent));
      chk("wd_err_after_pop", 64'(timeout_err), 64'd1);
      tick();
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      @(negedge clk);
      chk("wd_clear", 64'(timeout_err), 64'd0);
      // clear on the same edge the limit is reached: set wins
      req_data[0] = 32'h00A6_0505;
      req_vld     = 4'b0001;
      expect_pkt(0, 32'h00A6_0505);
      tick();
      req_vld = '0;
      repeat (63) tick();
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      @(negedge clk);
      chk("wd_set_wins", 64'(timeout_err), 64'd1);
      tick();
      popin = 1'b1;
      tick();
      popin = 1'b0;
      exp_sent++;
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      @(negedge clk);
      chk("wd_clear2", 64'(timeout_err), 64'd0);
      chk("wd_sent2", 64'(sent_cnt), 64'(exp_sent));

      // ---------------- async reset mid-SEND ----------------
      do_reset();
      req_data[0] = 32'h0077_0000;
      req_vld     = 4'b0001;
      acc_q.push_back(0);
      tick();
      req_vld = '0;
      @(negedge clk);
      chk("ar_pndng", 64'(pndng_i_in), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("ar_pndng_async", 64'(pndng_i_in), 64'd0);
      chk("ar_busy_async", 64'(busy), 64'd0);
      chk("ar_data_async", 64'(data_out_i_in), 64'd0);
      exp_sent = 0;
      @(posedge clk);
      #1 reset = 1'b1;
      send_pkt(3, 32'h0078_3333);
      for (int i = 0; i < NR; i++) req_data[i] = 32'h0079_0000 | 32'(i);
      req_vld = 4'b1111;
      expect_pkt(0, 32'h0079_0000);
      @(negedge clk);
      chk("ar_rr_first", 64'(req_rdy), 64'h1);
      tick();
      req_vld = '0;
      popin   = 1'b1;
      tick();
      popin   = 1'b0;
      exp_sent++;
      @(negedge clk);
      chk("ar_sent", 64'(sent_cnt), 64'(exp_sent));

      // ---------------- saturation ----------------
      do_reset();
      popin = 1'b1;
      tick();
      popin = 1'b0;
      @(negedge clk);
      chk("idle_pop_ignored", 64'(sent_cnt), 64'd0);
      for (int k = 0; k < 20; k++) send_pkt(1, 32'h0055_0000 + 32'(k));
      @(negedge clk);
      chk("sat_sent_wide", 64'(sent_cnt), 64'(exp_sent));
      chk("sat_sent_narrow", 64'(s_sent_cnt), 64'd15);
      chk("sat_drop_narrow", 64'(s_drop_cnt), 64'd0);

      tick();
      chk("acc_q_empty", 64'(acc_q.size()), 64'd0);
      chk("pop_q_empty", 64'(pop_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
